// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared register map, mode encodings and reset helpers for the LED blink bank
package led_blink_pkg;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PERIOD = 2'd1;
    localparam logic [1:0] SEL_DUTY   = 2'd2;
    localparam logic [1:0] SEL_COUNT  = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_BIT = 1;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PWM    = 1'b1
    } mode_e;

    // Channel i boots at twice the half-period of channel i-1.
    function automatic logic [31:0] rst_period(input logic [31:0] def, input int idx);
        return def << idx;
    endfunction

endpackage

// File: rtl/led_blink_bank_if.sv
// rtl/led_blink_bank_if.sv - register bus for the LED blink bank
interface led_blink_bank_if #(
    parameter int AW = 5
) ();

    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic          wren;
    logic          rden;

    modport master (
        output addr,
        output din,
        output wren,
        output rden,
        input  dout
    );

    modport slave (
        input  addr,
        input  din,
        input  wren,
        input  rden,
        output dout
    );

endinterface

// File: rtl/led_blink_chan.sv
// rtl/led_blink_chan.sv - one blink/PWM channel: control, shadowed period/duty, counter and LED flop
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int            CW         = 32,
    parameter logic [CW-1:0] RST_PERIOD = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          wr,
    input  logic [1:0]    sel,
    input  logic [CW-1:0] din,
    output logic          en,
    output logic          mode,
    output logic [CW-1:0] per_sh,
    output logic [CW-1:0] duty_sh,
    output logic [CW-1:0] cnt,
    output logic          led
);

    localparam logic [CW-1:0] RST_DUTY = RST_PERIOD >> 1;

    logic          en_q, en_d;
    mode_e         mode_q, mode_d;
    logic [CW-1:0] per_sh_q, per_sh_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] duty_sh_q, duty_sh_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          led_q, led_d;

    logic ctrl_wr, per_wr, duty_wr, cnt_wr;
    logic mode_chg, running, wrap, clear;

    always_comb begin
        ctrl_wr = wr && (sel == SEL_CTRL);
        per_wr  = wr && (sel == SEL_PERIOD);
        duty_wr = wr && (sel == SEL_DUTY);
        cnt_wr  = wr && (sel == SEL_COUNT);

        en_d      = ctrl_wr ? din[CTRL_EN_BIT] : en_q;
        mode_d    = ctrl_wr ? mode_e'(din[CTRL_MODE_BIT]) : mode_q;
        mode_chg  = ctrl_wr && (mode_d != mode_q);
        per_sh_d  = per_wr  ? din : per_sh_q;
        duty_sh_d = duty_wr ? din : duty_sh_q;

        // A zero active period parks the channel exactly like en=0.
        running = en_q && (per_q != '0);
        wrap    = tick && running && !cnt_wr && (cnt_q == per_q - CW'(1));
        clear   = !en_d || mode_chg || !running;

        per_d  = per_q;
        duty_d = duty_q;
        if (!running || wrap) begin
            per_d  = per_sh_d;
            duty_d = duty_sh_d;
        end

        cnt_d = cnt_q;
        if (clear || cnt_wr || wrap) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + CW'(1);
        end

        led_d = led_q;
        if (clear) begin
            led_d = 1'b0;
        end else if (mode_q == MODE_PWM) begin
            led_d = (cnt_q < duty_q);
        end else if (wrap) begin
            led_d = !led_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b1;
            mode_q    <= MODE_TOGGLE;
            per_sh_q  <= RST_PERIOD;
            per_q     <= RST_PERIOD;
            duty_sh_q <= RST_DUTY;
            duty_q    <= RST_DUTY;
            cnt_q     <= '0;
            led_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            per_sh_q  <= per_sh_d;
            per_q     <= per_d;
            duty_sh_q <= duty_sh_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
        end
    end

    assign en      = en_q;
    assign mode    = (mode_q == MODE_PWM);
    assign per_sh  = per_sh_q;
    assign duty_sh = duty_sh_q;
    assign cnt     = cnt_q;
    assign led     = led_q;

endmodule

// File: rtl/led_blink_bank.sv
// rtl/led_blink_bank.sv - bank of NCH blink/PWM LED channels with shared prescaler and register bus
module led_blink_bank
    import led_blink_pkg::*;
#(
    parameter int          NCH        = 8,
    parameter int          CW         = 32,
    parameter int          PRESCALE   = 1,
    parameter logic [31:0] DEF_PERIOD = 32'h005F5E10
) (
    input  logic              clk,
    input  logic              reset,
    led_blink_bank_if.slave   bus,
    output logic [NCH-1:0]    led
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [31:0]   dout_q, dout_d;
    logic [31:0]   addr_w;
    int            ch_idx;
    logic [1:0]    sel;
    logic [NCH-1:0] wr;

    logic [NCH-1:0] en_v;
    logic [NCH-1:0] mode_v;
    logic [CW-1:0]  psh_v [NCH];
    logic [CW-1:0]  dsh_v [NCH];
    logic [CW-1:0]  cnt_v [NCH];

    // Bits of din above CW only matter for reduced-width builds.
    logic unused_din;
    assign unused_din = ^bus.din;

    always_comb begin
        tick  = (pre_q == PW'(PRESCALE - 1));
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    always_comb begin
        addr_w = 32'(bus.addr);
        ch_idx = int'(addr_w >> 2);
        sel    = bus.addr[1:0];
        for (int i = 0; i < NCH; i++) begin
            wr[i] = bus.wren && (ch_idx == i);
        end
    end

    // Read data comes from the registered channel state, so a same-cycle write is not visible yet.
    always_comb begin
        dout_d = '0;
        if (bus.rden) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_idx == i) begin
                    case (sel)
                        SEL_CTRL:   dout_d = {30'b0, mode_v[i], en_v[i]};
                        SEL_PERIOD: dout_d = 32'(psh_v[i]);
                        SEL_DUTY:   dout_d = 32'(dsh_v[i]);
                        default:    dout_d = 32'(cnt_v[i]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            dout_q <= '0;
        end else begin
            pre_q  <= pre_d;
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        localparam logic [31:0] RP = rst_period(DEF_PERIOD, g);

        led_blink_chan #(
            .CW         (CW),
            .RST_PERIOD (RP[CW-1:0])
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .wr      (wr[g]),
            .sel     (sel),
            .din     (bus.din[CW-1:0]),
            .en      (en_v[g]),
            .mode    (mode_v[g]),
            .per_sh  (psh_v[g]),
            .duty_sh (dsh_v[g]),
            .cnt     (cnt_v[g]),
            .led     (led[g])
        );
    end

endmodule

// File: tb/tb_led_blink_bank.sv
// tb/tb_led_blink_bank.sv - self-checking bench for led_blink_bank
module tb_led_blink_bank;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    led_blink_bank_if #(.AW(4)) bus_a ();
    led_blink_bank_if #(.AW(5)) bus_b ();
    logic [3:0] led_a;
    logic [5:0] led_b;

    led_blink_bank #(.NCH(4), .CW(8), .PRESCALE(1), .DEF_PERIOD(32'd4)) dut_a (
        .clk (clk), .reset (reset), .bus (bus_a), .led (led_a)
    );
    led_blink_bank #(.NCH(6), .CW(8), .PRESCALE(3), .DEF_PERIOD(32'd4)) dut_b (
        .clk (clk), .reset (reset), .bus (bus_b), .led (led_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_en [4], m_mode [4], m_psh [4], m_per [4];
    int m_dsh [4], m_duty [4], m_cnt [4], m_led [4];
    int m_dout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ad(input int ch, input int sel);
        return 4'(ch * 4 + sel);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_per[i]  = (4 << i) & 255;
            m_duty[i] = m_per[i] / 2;
            m_psh[i]  = m_per[i];
            m_dsh[i]  = m_duty[i];
            m_en[i]   = 1;
            m_mode[i] = 0;
            m_cnt[i]  = 0;
            m_led[i]  = 0;
        end
        m_dout = 0;
    endtask

    // One clock of the bank as the register map describes it; PRESCALE=1, so every clock is a tick.
    task automatic model_step(input bit we, input bit re, input logic [3:0] a, input logic [31:0] d);
        int ch;
        int sel;
        ch  = int'(a) / 4;
        sel = int'(a) % 4;
        m_dout = 0;
        if (re) begin
            if (sel == 0)      m_dout = m_mode[ch] * 2 + m_en[ch];
            else if (sel == 1) m_dout = m_psh[ch];
            else if (sel == 2) m_dout = m_dsh[ch];
            else               m_dout = m_cnt[ch];
        end
        for (int i = 0; i < 4; i++) begin
            bit w, live, cw, wrap, chg, off;
            int ne, nm, nled, ncnt;
            w    = we && (ch == i);
            cw   = w && (sel == 3);
            live = (m_en[i] != 0) && (m_per[i] != 0);
            wrap = live && !cw && (m_cnt[i] == m_per[i] - 1);
            ne   = m_en[i];
            nm   = m_mode[i];
            if (w && sel == 0) begin
                ne = int'(d[0]);
                nm = int'(d[1]);
            end
            chg = (nm != m_mode[i]);
            if (w && sel == 1) m_psh[i] = int'(d & 32'hFF);
            if (w && sel == 2) m_dsh[i] = int'(d & 32'hFF);
            off = (ne == 0) || chg || !live;
            if (off)                nled = 0;
            else if (m_mode[i] == 1) nled = (m_cnt[i] < m_duty[i]) ? 1 : 0;
            else if (wrap)          nled = 1 - m_led[i];
            else                    nled = m_led[i];
            if (off || cw || wrap)  ncnt = 0;
            else                    ncnt = m_cnt[i] + 1;
            if (!live || wrap) begin
                m_per[i]  = m_psh[i];
                m_duty[i] = m_dsh[i];
            end
            m_en[i]   = ne;
            m_mode[i] = nm;
            m_led[i]  = nled;
            m_cnt[i]  = ncnt;
        end
    endtask

    task automatic cycle(input bit we, input bit re, input logic [3:0] a, input logic [31:0] d);
        logic [3:0] mv;
        bus_a.wren = we;
        bus_a.rden = re;
        bus_a.addr = a;
        bus_a.din  = d;
        @(posedge clk);
        model_step(we, re, a, d);
        #1;
        for (int i = 0; i < 4; i++) mv[i] = (m_led[i] != 0);
        check("led_vs_model", 32'(led_a), 32'(mv));
        check("dout_vs_model", bus_a.dout, 32'(m_dout));
    endtask

    task automatic idle_b();
        bus_b.wren = 1'b0;
        bus_b.rden = 1'b0;
        bus_b.addr = '0;
        bus_b.din  = '0;
    endtask

    task automatic do_reset();
        bus_a.wren = 1'b0;
        bus_a.rden = 1'b0;
        bus_a.addr = '0;
        bus_a.din  = '0;
        idle_b();
        reset = 1'b1;
        #2;
        check("reset_led_a", 32'(led_a), 32'd0);
        check("reset_led_b", 32'(led_b), 32'd0);
        check("reset_dout", bus_a.dout, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        idle_b();
        bus_a.wren = 1'b0;
        bus_a.rden = 1'b0;
        bus_a.addr = '0;
        bus_a.din  = '0;
        @(posedge clk);
        #1;

        // Default blink rates, both prescale settings.
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            cycle(0, 0, 4'd0, 32'd0);
            check("t1_led0", 32'(led_a[0]), 32'((c / 4) % 2));
            check("t1_led1", 32'(led_a[1]), 32'((c / 8) % 2));
            check("t1_led3", 32'(led_a[3]), 32'((c / 32) % 2));
            check("t1_b_led0", 32'(led_b[0]), 32'((c / 12) % 2));
            check("t1_b_led1", 32'(led_b[1]), 32'((c / 24) % 2));
        end

        // Period rewrite takes effect at the next wrap.
        do_reset();
        cycle(0, 0, 4'd0, 32'd0);
        cycle(1, 0, ad(0, 1), 32'd10);
        for (int c = 3; c <= 30; c++) begin
            cycle(0, 0, 4'd0, 32'd0);
            check("t2_led0", 32'(led_a[0]), (c < 4) ? 32'd0 : 32'((((c - 4) / 10) % 2 == 0) ? 1 : 0));
        end

        // PWM on channel 2.
        do_reset();
        cycle(1, 0, ad(2, 0), 32'd2);
        cycle(1, 0, ad(2, 1), 32'd10);
        cycle(1, 0, ad(2, 2), 32'd3);
        cycle(1, 0, ad(2, 0), 32'd3);
        for (int j = 1; j <= 30; j++) begin
            cycle(0, 0, 4'd0, 32'd0);
            check("t3_pwm", 32'(led_a[2]), 32'((((j - 1) % 10) < 3) ? 1 : 0));
        end
        cycle(1, 0, ad(2, 2), 32'd0);
        for (int j = 0; j < 12; j++) cycle(0, 0, 4'd0, 32'd0);
        for (int j = 0; j < 20; j++) begin
            cycle(0, 0, 4'd0, 32'd0);
            check("t3_duty0", 32'(led_a[2]), 32'd0);
        end
        cycle(1, 0, ad(2, 2), 32'd12);
        for (int j = 0; j < 12; j++) cycle(0, 0, 4'd0, 32'd0);
        for (int j = 0; j < 20; j++) begin
            cycle(0, 0, 4'd0, 32'd0);
            check("t3_duty12", 32'(led_a[2]), 32'd1);
        end

        // Disable and re-enable channel 1.
        do_reset();
        for (int c = 1; c <= 10; c++) cycle(0, 0, 4'd0, 32'd0);
        check("t4_led1_before", 32'(led_a[1]), 32'd1);
        cycle(1, 0, ad(1, 0), 32'd0);
        check("t4_led1_off", 32'(led_a[1]), 32'd0);
        cycle(0, 1, ad(1, 3), 32'd0);
        check("t4_count_off", bus_a.dout, 32'd0);
        cycle(1, 0, ad(1, 0), 32'd1);
        for (int c = 14; c <= 21; c++) begin
            cycle(0, 0, 4'd0, 32'd0);
            check("t4_restart", 32'(led_a[1]), (c == 21) ? 32'd1 : 32'd0);
        end

        // Read path, including out-of-range channels on the 6-channel bank.
        do_reset();
        for (int c = 1; c <= 9; c++) cycle(0, 0, 4'd0, 32'd0);
        bus_b.rden = 1'b1;
        bus_b.addr = 5'd25;
        cycle(0, 1, ad(3, 3), 32'd0);
        check("t5_live_cnt", bus_a.dout, 32'd9);
        check("t5_b_ch6", bus_b.dout, 32'd0);
        bus_b.addr = 5'd21;
        cycle(1, 1, ad(0, 1), 32'd50);
        check("t5_rw_old", bus_a.dout, 32'd4);
        check("t5_b_ch5", bus_b.dout, 32'd128);
        bus_b.wren = 1'b1;
        bus_b.addr = 5'd29;
        bus_b.din  = 32'd77;
        cycle(0, 1, ad(0, 1), 32'd0);
        check("t5_rw_new", bus_a.dout, 32'd50);
        check("t5_b_ch7", bus_b.dout, 32'd0);
        idle_b();
        cycle(0, 1, ad(2, 0), 32'd0);
        check("t5_ctrl", bus_a.dout, 32'd1);
        cycle(0, 0, 4'd0, 32'd0);
        check("t5_dout_idle", bus_a.dout, 32'd0);

        // Asynchronous reset in the middle of a count.
        do_reset();
        for (int c = 1; c <= 12; c++) cycle(0, 0, 4'd0, 32'd0);
        cycle(0, 1, ad(3, 3), 32'd0);
        check("t6_pre_dout", bus_a.dout, 32'd12);
        check("t6_pre_led", 32'(led_a[1:0]), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_led", 32'(led_a), 32'd0);
        check("t6_async_led_b", 32'(led_b), 32'd0);
        check("t6_async_dout", bus_a.dout, 32'd0);
        do_reset();
        cycle(0, 1, ad(0, 3), 32'd0);
        check("t6_cnt_zero", bus_a.dout, 32'd0);
        cycle(0, 1, ad(0, 1), 32'd0);
        check("t6_period_reload", bus_a.dout, 32'd4);

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit we, re;
            int ch, sel;
            logic [31:0] d;
            we  = ($urandom_range(0, 9) < 3);
            re  = ($urandom_range(0, 1) == 1);
            ch  = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            if (sel == 0)      d = 32'($urandom_range(0, 3));
            else if (sel == 1) d = 32'($urandom_range(0, 12));
            else if (sel == 2) d = 32'($urandom_range(0, 14));
            else               d = $urandom;
            cycle(we, re, ad(ch, sel), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
